card_datapath_tally: RTL and testbench
======================================

Name: card_datapath_tally

Overview:
- Datapath stage that sits directly around the baccarat round state machine.
- Holds the six dealt card registers and loads them from the upstream card source on the state machine's load strobes.
- Computes the player and dealer scores, and the player's third card, that feed back into the state machine.
- Consumes the state machine's win lights to keep saturating per-session win/tie tallies that survive new rounds.

Parameters:
TALLY_W, 8, width of each tally counter (saturating at 2^TALLY_W-1)

Ports:
slow_clock  in  1  single clock; all state changes on posedge
resetb  in  1  reset, synchronous, active-high (1 = reset); clears cards, tallies, edge detector
new_round  in  1  synchronous clear of all six card registers; tallies untouched
new_card  in  4  card from upstream source (1=A, 2-10 face value, 11=J, 12=Q, 13=K)
load_pcard1, load_pcard2, load_pcard3  in  1 each  load strobes from state machine
load_dcard1, load_dcard2, load_dcard3  in  1 each  load strobes from state machine
player_win_light, dealer_win_light  in  1 each  win lights from state machine
pcard1, pcard2, pcard3  out  4 each  player card registers
dcard1, dcard2, dcard3  out  4 each  dealer card registers
pscore, dscore  out  4 each  hand scores, 0-9
player_wins, dealer_wins, ties, rounds  out  TALLY_W each  session tallies
last_result  out  2  00 none, 01 player, 10 dealer, 11 tie

Behaviour:
- Reset (resetb=1 at posedge):
  - All card registers, tallies, last_result and the edge-detect flop go to 0.
  - pscore and dscore therefore read 0 the following cycle.
- Priority per posedge: resetb > new_round > load strobes.
- Card registers:
  - On posedge with load_X=1, register X <= new_card; a register holds otherwise.
  - Several strobes high in one cycle: every strobed register loads the same new_card.
  - new_round=1 clears all six registers to 0 and ignores strobes that cycle.
  - 0 means "no card".
- Card value:
  - val(c) = c for c in 1..9.
  - val(c) = 0 for c = 0 and c in 10..15; illegal codes 14 and 15 are loaded unchanged but score as 0.
- Scores:
  - Combinational from the registers: pscore = (val(pcard1)+val(pcard2)+val(pcard3)) mod 10; dscore likewise.
  - Internal sum is at least 5 bits (max 27); the result is always 0-9.
  - Latency: a card strobed at edge N is reflected in its score after edge N, i.e. it is visible to the state machine's decision at edge N+1.
  - pcard3 output is the register itself, 0 until loaded.
- Round-end detection:
  - win_any = player_win_light | dealer_win_light; win_prev is registered win_any.
  - A round ends on the cycle where win_any=1 and win_prev=0.
  - Lights held high for many cycles count exactly once.
  - Lights dropping and re-rising (after the state machine is reset for the next round) count again.
- On a round end:
  - rounds += 1.
  - Both lights high: ties += 1, last_result = 11.
  - Player light only: player_wins += 1, last_result = 01.
  - Dealer light only: dealer_wins += 1, last_result = 10.
  - Tally updates are registered, visible one cycle after the edge is detected.
- Saturation: each counter stops at 2^TALLY_W-1 and holds; other counters keep counting.
- new_round has no effect on tallies, win_prev or last_result.
  - A round end coinciding with new_round is still counted.
- resetb asserted mid-round or mid-tally clears everything; a light already high when resetb deasserts is not counted, because win_prev reset to 0 is re-armed only after one sampled cycle.
  - Concretely: win_prev loads win_any in the reset cycle's successor, and no count occurs in the first cycle after reset.
- No combinational path from load strobes or new_card to any output other than through registers.

Test Plan:
- Reset, then load pcard1=9, pcard2=13, dcard1=4, dcard2=12 on successive edges -> pscore=9, dscore=4; pcard3=0.
- pcard1=7, pcard2=8, pcard3=9 -> pscore=4 (24 mod 10). new_round -> all cards 0, pscore=0, tallies unchanged.
- player_win_light held high for 10 cycles -> player_wins=1, rounds=1, last_result=01 exactly one cycle after the rise; no further increments.
- Both lights rise together, drop, then dealer light alone rises -> ties=1, dealer_wins=1, rounds=2, last_result=10.
- TALLY_W=2, five player-win rounds -> player_wins=3 saturated, rounds=3; dealer_wins and ties=0.
- load_pcard1 and new_round in the same cycle with new_card=5 -> pcard1=0. resetb with lights high -> all outputs 0, and no count on the cycle after reset even with the lights still high.

Source files
------------

// File: rtl/card_datapath_tally.sv
// Baccarat datapath: six dealt-card registers, combinational hand scores, and
// saturating per-session win/tie tallies driven by the round FSM's win lights.
module card_datapath_tally #(
    parameter int TALLY_W = 8
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               new_round,
    input  logic [3:0]         new_card,
    input  logic               load_pcard1,
    input  logic               load_pcard2,
    input  logic               load_pcard3,
    input  logic               load_dcard1,
    input  logic               load_dcard2,
    input  logic               load_dcard3,
    input  logic               player_win_light,
    input  logic               dealer_win_light,
    output logic [3:0]         pcard1,
    output logic [3:0]         pcard2,
    output logic [3:0]         pcard3,
    output logic [3:0]         dcard1,
    output logic [3:0]         dcard2,
    output logic [3:0]         dcard3,
    output logic [3:0]         pscore,
    output logic [3:0]         dscore,
    output logic [TALLY_W-1:0] player_wins,
    output logic [TALLY_W-1:0] dealer_wins,
    output logic [TALLY_W-1:0] ties,
    output logic [TALLY_W-1:0] rounds,
    output logic [1:0]         last_result
);

    logic [3:0]         pcard1_q, pcard2_q, pcard3_q;
    logic [3:0]         dcard1_q, dcard2_q, dcard3_q;
    logic [TALLY_W-1:0] player_wins_q, player_wins_d;
    logic [TALLY_W-1:0] dealer_wins_q, dealer_wins_d;
    logic [TALLY_W-1:0] ties_q, ties_d;
    logic [TALLY_W-1:0] rounds_q, rounds_d;
    logic [1:0]         last_result_q, last_result_d;
    logic               win_prev_q;
    logic               armed_q;
    logic               win_any;
    logic               round_end;

    // Face cards, tens and illegal codes all count as zero.
    function automatic logic [3:0] card_val(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
    endfunction

    function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c);
        logic [4:0] s;
        s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
        if (s >= 5'd20) begin
            s = s - 5'd20;
        end else if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (v == {TALLY_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge slow_clock) begin
        if (resetb || new_round) begin
            pcard1_q <= 4'd0;
            pcard2_q <= 4'd0;
            pcard3_q <= 4'd0;
            dcard1_q <= 4'd0;
            dcard2_q <= 4'd0;
            dcard3_q <= 4'd0;
        end else begin
            if (load_pcard1) pcard1_q <= new_card;
            if (load_pcard2) pcard2_q <= new_card;
            if (load_pcard3) pcard3_q <= new_card;
            if (load_dcard1) dcard1_q <= new_card;
            if (load_dcard2) dcard2_q <= new_card;
            if (load_dcard3) dcard3_q <= new_card;
        end
    end

    // armed_q masks the first cycle after reset so lights held through reset never count.
    assign win_any   = player_win_light | dealer_win_light;
    assign round_end = win_any & ~win_prev_q & armed_q;

    always_comb begin
        player_wins_d = player_wins_q;
        dealer_wins_d = dealer_wins_q;
        ties_d        = ties_q;
        rounds_d      = rounds_q;
        last_result_d = last_result_q;
        if (round_end) begin
            rounds_d = sat_inc(rounds_q);
            if (player_win_light && dealer_win_light) begin
                ties_d        = sat_inc(ties_q);
                last_result_d = 2'b11;
            end else if (player_win_light) begin
                player_wins_d = sat_inc(player_wins_q);
                last_result_d = 2'b01;
            end else begin
                dealer_wins_d = sat_inc(dealer_wins_q);
                last_result_d = 2'b10;
            end
        end
    end

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            player_wins_q <= '0;
            dealer_wins_q <= '0;
            ties_q        <= '0;
            rounds_q      <= '0;
            last_result_q <= 2'b00;
            win_prev_q    <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            player_wins_q <= player_wins_d;
            dealer_wins_q <= dealer_wins_d;
            ties_q        <= ties_d;
            rounds_q      <= rounds_d;
            last_result_q <= last_result_d;
            win_prev_q    <= win_any;
            armed_q       <= 1'b1;
        end
    end

    assign pcard1      = pcard1_q;
    assign pcard2      = pcard2_q;
    assign pcard3      = pcard3_q;
    assign dcard1      = dcard1_q;
    assign dcard2      = dcard2_q;
    assign dcard3      = dcard3_q;
    assign pscore      = hand_score(pcard1_q, pcard2_q, pcard3_q);
    assign dscore      = hand_score(dcard1_q, dcard2_q, dcard3_q);
    assign player_wins = player_wins_q;
    assign dealer_wins = dealer_wins_q;
    assign ties        = ties_q;
    assign rounds      = rounds_q;
    assign last_result = last_result_q;

endmodule

// File: tb/tb_card_datapath_tally.sv
// Bench for card_datapath_tally: directed stimulus, a behavioural model checked
// every negedge on a TALLY_W=8 and a TALLY_W=2 instance, plus literal spot checks.
module tb_card_datapath_tally;

    logic       clk = 1'b0;
    logic       resetb = 1'b1, new_round = 1'b0;
    logic [3:0] new_card = 4'd0;
    logic       lp1 = 0, lp2 = 0, lp3 = 0, ld1 = 0, ld2 = 0, ld3 = 0;
    logic       pwl = 0, dwl = 0;

    logic [3:0] a_p1, a_p2, a_p3, a_d1, a_d2, a_d3, a_ps, a_ds;
    logic [7:0] a_pw, a_dw, a_ti, a_rn;
    logic [1:0] a_lr;
    logic [3:0] b_p1, b_p2, b_p3, b_d1, b_d2, b_d3, b_ps, b_ds;
    logic [1:0] b_pw, b_dw, b_ti, b_rn;
    logic [1:0] b_lr;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    always #5 clk = ~clk;

    card_datapath_tally #(.TALLY_W(8)) dut_a (
        .slow_clock(clk), .resetb(resetb), .new_round(new_round), .new_card(new_card),
        .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
        .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
        .player_win_light(pwl), .dealer_win_light(dwl),
        .pcard1(a_p1), .pcard2(a_p2), .pcard3(a_p3),
        .dcard1(a_d1), .dcard2(a_d2), .dcard3(a_d3),
        .pscore(a_ps), .dscore(a_ds),
        .player_wins(a_pw), .dealer_wins(a_dw), .ties(a_ti), .rounds(a_rn),
        .last_result(a_lr));

    card_datapath_tally #(.TALLY_W(2)) dut_b (
        .slow_clock(clk), .resetb(resetb), .new_round(new_round), .new_card(new_card),
        .load_pcard1(lp1), .load_pcard2(lp2), .load_pcard3(lp3),
        .load_dcard1(ld1), .load_dcard2(ld2), .load_dcard3(ld3),
        .player_win_light(pwl), .dealer_win_light(dwl),
        .pcard1(b_p1), .pcard2(b_p2), .pcard3(b_p3),
        .dcard1(b_d1), .dcard2(b_d2), .dcard3(b_d3),
        .pscore(b_ps), .dscore(b_ds),
        .player_wins(b_pw), .dealer_wins(b_dw), .ties(b_ti), .rounds(b_rn),
        .last_result(b_lr));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw event counts, cards as plain arrays; saturation applied on read.
    int mp[3], md[3];
    int cnt_p, cnt_d, cnt_t, cnt_r, m_last;
    bit m_prev, m_armed;

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int sat(input int raw, input int w);
        return (raw > (1 << w) - 1) ? (1 << w) - 1 : raw;
    endfunction

    always @(posedge clk) begin
        if (resetb) begin
            for (int i = 0; i < 3; i++) begin mp[i] = 0; md[i] = 0; end
            cnt_p = 0; cnt_d = 0; cnt_t = 0; cnt_r = 0; m_last = 0;
            m_prev = 0; m_armed = 0;
        end else begin
            if (new_round) begin
                for (int i = 0; i < 3; i++) begin mp[i] = 0; md[i] = 0; end
            end else begin
                if (lp1) mp[0] = new_card;
                if (lp2) mp[1] = new_card;
                if (lp3) mp[2] = new_card;
                if (ld1) md[0] = new_card;
                if (ld2) md[1] = new_card;
                if (ld3) md[2] = new_card;
            end
            if ((pwl || dwl) && !m_prev && m_armed) begin
                cnt_r++;
                if (pwl && dwl) begin cnt_t++; m_last = 3; end
                else if (pwl)   begin cnt_p++; m_last = 1; end
                else            begin cnt_d++; m_last = 2; end
            end
            m_prev  = pwl || dwl;
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_pcard1", a_p1, mp[0]); chk("a_pcard2", a_p2, mp[1]); chk("a_pcard3", a_p3, mp[2]);
            chk("a_dcard1", a_d1, md[0]); chk("a_dcard2", a_d2, md[1]); chk("a_dcard3", a_d3, md[2]);
            chk("a_pscore", a_ps, (val(mp[0]) + val(mp[1]) + val(mp[2])) % 10);
            chk("a_dscore", a_ds, (val(md[0]) + val(md[1]) + val(md[2])) % 10);
            chk("a_player_wins", a_pw, sat(cnt_p, 8));
            chk("a_dealer_wins", a_dw, sat(cnt_d, 8));
            chk("a_ties", a_ti, sat(cnt_t, 8));
            chk("a_rounds", a_rn, sat(cnt_r, 8));
            chk("a_last_result", a_lr, m_last);
            chk("b_pscore", b_ps, (val(mp[0]) + val(mp[1]) + val(mp[2])) % 10);
            chk("b_player_wins", b_pw, sat(cnt_p, 2));
            chk("b_dealer_wins", b_dw, sat(cnt_d, 2));
            chk("b_ties", b_ti, sat(cnt_t, 2));
            chk("b_rounds", b_rn, sat(cnt_r, 2));
            chk("b_last_result", b_lr, m_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] c, input int which);
        new_card = c;
        case (which)
            0: lp1 = 1; 1: lp2 = 1; 2: lp3 = 1;
            3: ld1 = 1; 4: ld2 = 1; default: ld3 = 1;
        endcase
        tick();
        {lp1, lp2, lp3, ld1, ld2, ld3} = '0;
    endtask

    task automatic do_reset();
        resetb = 1'b1;
        tick(); tick();
        resetb = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_en = 1;
        chk("rst_pscore", a_ps, 0);
        chk("rst_rounds", a_rn, 0);
        chk("rst_last", a_lr, 0);

        load(4'd9, 0); load(4'd13, 1); load(4'd4, 3); load(4'd12, 4);
        chk("ps_9_K", a_ps, 9);
        chk("ds_4_Q", a_ds, 4);
        chk("pcard3_empty", a_p3, 0);

        load(4'd7, 0); load(4'd8, 1); load(4'd9, 2); load(4'd14, 5);
        chk("ps_24", a_ps, 4);
        chk("dcard3_illegal", a_d3, 14);
        chk("ds_illegal_zero", a_ds, 4);
        new_round = 1; tick(); new_round = 0;
        chk("nr_pcard1", a_p1, 0);
        chk("nr_pscore", a_ps, 0);

        pwl = 1; tick();
        chk("pw_one", a_pw, 1);
        chk("pw_rounds", a_rn, 1);
        chk("pw_last", a_lr, 1);
        repeat (9) tick();
        chk("pw_held", a_pw, 1);
        chk("pw_held_rounds", a_rn, 1);
        pwl = 0; tick();

        pwl = 1; dwl = 1; tick();
        chk("tie_one", a_ti, 1);
        chk("tie_last", a_lr, 3);
        pwl = 0; dwl = 0; tick();
        dwl = 1; tick();
        chk("dw_one", a_dw, 1);
        chk("dw_rounds", a_rn, 3);
        chk("dw_last", a_lr, 2);
        dwl = 0; tick();

        do_reset();
        tick();
        for (int r = 0; r < 5; r++) begin
            pwl = 1;
            new_round = (r == 2);
            tick();
            new_round = 0; pwl = 0;
            tick();
        end
        chk("sat_b_pw", b_pw, 3);
        chk("sat_b_rounds", b_rn, 3);
        chk("sat_b_dw", b_dw, 0);
        chk("sat_b_ties", b_ti, 0);
        chk("sat_a_pw", a_pw, 5);

        load(4'd3, 0);
        new_card = 4'd5; lp1 = 1; new_round = 1; tick(); lp1 = 0; new_round = 0;
        chk("nr_over_load", a_p1, 0);

        pwl = 1; dwl = 1;
        do_reset();
        chk("rst_lights_rounds", a_rn, 0);
        tick();
        chk("post_rst_no_count", a_rn, 0);
        chk("post_rst_no_tie", a_ti, 0);
        tick();
        chk("post_rst_still_none", a_rn, 0);
        pwl = 0; dwl = 0; tick();
        pwl = 1; tick();
        chk("rearm_count", a_pw, 1);
        pwl = 0; tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
